// File: rtl/parity_frame_feeder.sv
// parity_frame_feeder: buffers producer nibbles in a 2-entry FIFO. Each word
// becomes a 4-beat frame to a downstream parity checker, with start/last
// markers, the expected parity bit on the last beat, and a frame counter.
// Build option: define PARITY_FRAME_ODD_EN for odd parity (default is even).
module parity_frame_feeder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [3:0]       out_data,
   output logic             out_valid,
   output logic             out_start,
   output logic             out_last,
   output logic             out_parity,
   output logic [CNT_W-1:0] frame_cnt
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state_q, state_d;
   logic [1:0]       beat_q, beat_d;
   logic [3:0]       data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [3:0]       fifo_q [2];
   logic [3:0]       fifo_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       occ_q, occ_d;

   logic             push;
   logic             pop;
   logic             fifo_nempty;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Parity bit the downstream checker should see for a nibble.
   function automatic logic parity_of(input logic [3:0] d);
`ifdef PARITY_FRAME_ODD_EN
      return ~(d[0] ^ d[1] ^ d[2] ^ d[3]);
`else
      return d[0] ^ d[1] ^ d[2] ^ d[3];
`endif
   endfunction

   // Ready depends only on registered occupancy, so it never sees in_valid.
   assign in_ready    = (occ_q != 2'd2);
   assign push        = in_valid && in_ready;
   assign fifo_nempty = (occ_q != 2'd0);

   // FIFO storage, pointers and occupancy; push and pop may share an edge.
   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) begin
         fifo_d[wr_ptr_q] = in_data;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   // Frame sequencer: load a word, hold it for four beats, chain frames
   // back-to-back while the FIFO has data.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            data_d = 4'd0;
            beat_d = 2'd0;
            if (fifo_nempty) begin
               pop     = 1'b1;
               data_d  = fifo_q[rd_ptr_q];
               state_d = SEND;
            end
         end
         SEND: begin
            beat_d = beat_q + 2'd1;
            if (beat_q == 2'd3) begin
               cnt_d  = cnt_q + CNT_ONE;
               beat_d = 2'd0;
               if (fifo_nempty) begin
                  pop    = 1'b1;
                  data_d = fifo_q[rd_ptr_q];
               end else begin
                  data_d  = 4'd0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            beat_d  = 2'd0;
            data_d  = 4'd0;
         end
      endcase
   end

   // Control state, output word and counter; reset aborts any frame and
   // discards buffered words by clearing occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         beat_q   <= 2'd0;
         data_q   <= 4'd0;
         cnt_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // FIFO storage needs no reset: occupancy alone says what is valid.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   assign out_valid  = (state_q == SEND);
   assign out_start  = out_valid && (beat_q == 2'd0);
   assign out_last   = out_valid && (beat_q == 2'd3);
   assign out_data   = data_q;
   assign out_parity = out_last ? parity_of(data_q) : 1'b0;
   assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_parity_frame_feeder.sv
// Scoreboard bench for parity_frame_feeder (built with CNT_W=2 so the
// frame counter wraps within a short run).
module tb_parity_frame_feeder;

   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [3:0]       in_data = 4'd0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [3:0]       out_data;
   logic             out_valid;
   logic             out_start;
   logic             out_last;
   logic             out_parity;
   logic [CNT_W-1:0] frame_cnt;

   parity_frame_feeder #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_start (out_start),
      .out_last  (out_last),
      .out_parity(out_parity),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic exp_par(input logic [3:0] d);
      logic p;
      p = d[0] ^ d[1] ^ d[2] ^ d[3];
`ifdef PARITY_FRAME_ODD_EN
      p = ~p;
`endif
      return p;
   endfunction

   // Reference model state
   logic [3:0]       sb_q[$];
   int               m_occ = 0;
   bit               pend_push = 0;
   bit               exp_start = 0;
   bit               exp_valid = 0;
   int               m_beat = 0;
   logic [3:0]       cur = 4'd0;
   logic [CNT_W-1:0] exp_cnt = '0;
   bit               armed = 0;
   bit               prev_rst = 0;

   // Monitor: applies what the last rising edge did to the model, compares,
   // then predicts what the coming edge will do.
   always @(negedge clk) begin
      bit last;
      if (prev_rst) begin
         m_occ = 0; sb_q.delete(); exp_cnt = '0;
         exp_valid = 0; exp_start = 0; m_beat = 0; cur = 4'd0;
      end else begin
         if (pend_push) m_occ++;
         if (exp_start) m_occ--;
         if (exp_start) begin
            m_beat = 0;
            if (sb_q.size() == 0) chk("sb_underflow", 0, 1);
            else cur = sb_q.pop_front();
         end else if (exp_valid) begin
            m_beat++;
         end
      end
      last = exp_valid && (m_beat == 3);
      if (armed) begin
         chk("out_valid",  out_valid,  exp_valid);
         chk("out_start",  out_start,  exp_start);
         chk("out_last",   out_last,   last);
         chk("out_data",   out_data,   exp_valid ? cur : 4'd0);
         chk("out_parity", out_parity, last ? exp_par(cur) : 1'b0);
         chk("frame_cnt",  frame_cnt,  exp_cnt);
         chk("in_ready",   in_ready,   m_occ < 2);
      end
      if (rst) begin
         armed = 1; prev_rst = 1; pend_push = 0;
      end else begin
         prev_rst  = 0;
         pend_push = in_valid && (m_occ < 2);
         if (pend_push) sb_q.push_back(in_data);
         if (last) exp_cnt = exp_cnt + 1'b1;
         exp_start = (m_occ > 0) && (!exp_valid || last);
         exp_valid = exp_start || (exp_valid && !last);
      end
   end

   task automatic push_word(input logic [3:0] d);
      bit ok;
      ok = 0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) chk("push_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      bit seen;
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(2);

      // Single frame
      push_word(4'b1011);
      idle(8);

      // Three back-to-back frames, FIFO fills
      push_word(4'h3);
      push_word(4'h7);
      push_word(4'hF);
      idle(16);

      // Valid held with changing data while not ready
      push_word(4'h1);
      push_word(4'h2);
      push_word(4'h4);
      for (int i = 0; i < 10; i++) begin
         in_valid = !in_ready;
         in_data  = 4'($urandom_range(0, 15));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      idle(20);

      // Reset during beat 2 of frame 5 with a word queued
      push_word(4'h5);
      push_word(4'h9);
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_start && out_data == 4'h5) begin seen = 1; break; end
      end
      if (!seen) chk("wait_frame5", 0, 1);
      idle(2);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(10);

      // Five frames for counter wrap
      for (int i = 0; i < 5; i++) push_word(4'($urandom_range(0, 15)));
      idle(25);

      // Random traffic
      for (int i = 0; i < 20; i++) begin
         push_word(4'($urandom_range(0, 15)));
         idle($urandom_range(0, 5));
      end

      seen = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && !exp_valid && !pend_push) begin seen = 1; break; end
      end
      if (!seen) chk("drain_timeout", 0, 1);
      idle(3);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
